// File: rtl/apb_slave_regfile.sv
// APB completer with a small 32-bit register file and a configurable number
// of wait states. Register 0 is a read-only ID, the rest are scratch/control.
module apb_slave_regfile #(
    parameter int unsigned SLAVE_ID    = 0,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h0000_0019
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [2:0]  pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_W   = 10;
    localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_CYCLES);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [11:0]      r_addr;
    logic             r_write;
    logic [31:0]      r_wdata;
    logic [31:0]      r_regs [1:NUM_REGS-1];
    logic             r_pready;
    logic             r_pslverr;
    logic [31:0]      r_prdata;

    logic             w_sel;
    logic             w_capture;
    logic             w_pready_nxt;
    logic             w_wr_en;
    logic [11:0]      w_addr;
    logic             w_write;
    logic [IDX_W-1:0] w_idx;
    logic             w_err;
    logic [31:0]      w_rdata;
    logic             w_unused_bits;

    assign w_sel         = pselx[SLAVE_ID];
    assign w_unused_bits = &{1'b0, paddr[31:12], pselx};

    // Decode uses live bus values in the setup cycle, captured values afterwards
    assign w_addr  = (r_state == S_IDLE) ? paddr[11:0] : r_addr;
    assign w_write = (r_state == S_IDLE) ? pwrite : r_write;
    assign w_idx   = w_addr[11:2];
    assign w_err   = (32'(w_idx) >= 32'(NUM_REGS)) || (w_addr[1:0] != 2'b00) ||
                     (w_write && (w_idx == IDX_W'(0)));

    // Read mux over the register file; index 0 is the constant ID
    always_comb begin
        w_rdata = 32'h0;
        if (w_idx == IDX_W'(0)) begin
            w_rdata = ID_VALUE;
        end
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_rdata = r_regs[i];
            end
        end
    end

    // State register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, wait counter and response-timing decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;
        w_pready_nxt = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel && !penable) begin
                    w_capture    = 1'b1;
                    w_cnt_nxt    = LP_WAIT;
                    w_state_nxt  = S_ACCESS;
                    w_pready_nxt = (LP_WAIT == CNT_W'(0));
                end
            end
            S_ACCESS: begin
                if (!w_sel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != CNT_W'(0)) begin
                    w_cnt_nxt    = r_cnt - CNT_W'(1);
                    w_pready_nxt = (r_cnt == CNT_W'(1));
                end else begin
                    w_state_nxt = S_IDLE;
                    w_wr_en     = r_write && !w_err;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Wait counter and captured transfer attributes
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_capture) begin
                r_addr  <= paddr[11:0];
                r_write <= pwrite;
                r_wdata <= pwdata;
            end
        end
    end

    // Registered response: valid only in the single pready cycle
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pready_nxt && w_err;
            r_prdata  <= (w_pready_nxt && !w_err && !w_write) ? w_rdata : 32'h0;
        end
    end

    // Register file write at the edge closing the pready cycle
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                if (w_wr_en && (r_addr[11:2] == IDX_W'(i))) begin
                    r_regs[i] <= r_wdata;
                end
            end
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule
